demux_2x8_stream: RTL and testbench
===================================

Name: demux_2x8_stream

Overview:
- Inverse of the team's 2:1 byte selector. One 8-bit input stream is routed to one of two 8-bit output streams, chosen per byte by SEL.
- Each output owns a small FIFO, so a stalled consumer on one side does not lose data.
- A stalled consumer only blocks input bytes addressed to it.
- Sits between a byte producer and two downstream consumers (for example, two Mux2x8-fed paths) in the datapath.

Parameters:
- DEPTH, 4, entries per output FIFO; power of 2, minimum 2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- ENT  input  8  input byte.
- ENT_VALID  input  1  input byte valid.
- SEL  input  1  destination: 0 = OUT1, 1 = OUT2; sampled with ENT.
- ENT_READY  output  1  block can accept the byte for the current SEL.
- OUT1  output  8  head byte of FIFO 1.
- OUT1_VALID  output  1  FIFO 1 not empty.
- OUT1_READY  input  1  consumer 1 takes the head byte.
- OUT2  output  8  head byte of FIFO 2.
- OUT2_VALID  output  1  FIFO 2 not empty.
- OUT2_READY  input  1  consumer 2 takes the head byte.
- CNT1  output  8  bytes accepted for OUT1, wraps modulo 256.
- CNT2  output  8  bytes accepted for OUT2, wraps modulo 256.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - both FIFOs are emptied and pointers/occupancy cleared;
  - OUT1_VALID = OUT2_VALID = 0, OUT1 = OUT2 = 8'h00, CNT1 = CNT2 = 0.
  - Reset mid-transfer discards all stored bytes; there is no partial flush.
- ENT_READY is combinational: ENT_READY = !full[SEL]. It depends on SEL only, not on ENT_VALID.
- Accept occurs when ENT_VALID && ENT_READY at the rising edge:
  - the byte is written to FIFO[SEL];
  - the matching CNTx increments, 8'hFF -> 8'h00.
- A byte offered to a full FIFO is not accepted and nothing is dropped. The producer must hold ENT/SEL/ENT_VALID until ENT_READY=1.
- Pop occurs when OUTx_VALID && OUTx_READY at the rising edge: the head advances.
- OUTx_READY while empty has no effect.
- Latency: a byte accepted at edge N is visible on OUTx with OUTx_VALID=1 after edge N. There is no same-cycle bypass into an empty FIFO.
- OUTx presents the head entry whenever OUTx_VALID=1 and holds stable while VALID=1 and READY=0. Its value while VALID=0 is not checked.
- Simultaneous push and pop on the same FIFO (not full) leaves occupancy unchanged, and data order is preserved.
- No push is possible when full, because ENT_READY is low. A pop while full frees an entry, and ENT_READY rises on the next cycle.
- Push to one FIFO and pop from the other in the same cycle are fully independent.
- Order is FIFO per output. No ordering relation exists between OUT1 and OUT2.
- Pointers are AW bits and wrap naturally. Occupancy is an (AW+1)-bit counter:
  - full when occupancy == DEPTH;
  - empty when occupancy == 0.
- There are no error states and no state machine beyond the per-FIFO pointer/occupancy registers.

Decomposition:
- Shared package demux_pkg:
  - BYTE_W = 8;
  - typedef byte_t (logic [7:0]);
  - localparam SEL_OUT1 = 1'b0, SEL_OUT2 = 1'b1.
- Sub-module byte_fifo (DEPTH parameter), instantiated twice.
  - Ports: CLK, RESET_N, push, din, pop, dout, full, empty.
- The top level contains only routing logic, ENT_READY, and the two counters.

Test Plan:
- Reset, then ENT=8'hA5 SEL=0 VALID=1 for one cycle -> OUT1_VALID=1, OUT1=8'hA5 on the next cycle; OUT2_VALID stays 0; CNT1=1, CNT2=0.
- OUT2_READY=0; push 8'h10, 8'h11, 8'h12, 8'h13 with SEL=1 -> ENT_READY=0 after the 4th byte while SEL=1. With SEL=0, ENT_READY=1 and 8'h55 reaches OUT1. Releasing OUT2_READY yields 10, 11, 12, 13 in order.
- Continuous push/pop on OUT1 with OUT1_READY=1, bytes 0..9 back-to-back -> output 0..9, one per cycle after 1-cycle latency; occupancy never exceeds 1; CNT1=10.
- Push 300 bytes to OUT2 with the consumer always ready -> CNT2 = 300 mod 256 = 44; no byte lost or duplicated.
- Hold a full FIFO 1 with ENT_VALID=1 and SEL=0 for 5 cycles -> no accept and CNT1 unchanged. Pulse OUT1_READY once -> exactly one accept on the following cycle.
- Load 3 bytes into each FIFO, then assert RESET_N=0 asynchronously mid-cycle -> VALIDs drop immediately and counters read 0. After release, the first new byte appears with no stale data.

Source files
------------

// File: rtl/demux_2x8_stream_pkg.sv
// Shared types and constants for the 1-to-2 byte stream demultiplexer.
package demux_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Destination encoding carried on SEL alongside each input byte.
    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

endpackage

// File: rtl/demux_2x8_stream_fifo.sv
// Small synchronous byte FIFO with an occupancy counter; one per output stream.
// Push is ignored when full and pop is ignored when empty, so callers may
// drive them loosely. dout reads 8'h00 while empty so the output is clean after reset.
module byte_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  CLK,
    input  logic  RESET_N,
    input  logic  push,
    input  byte_t din,
    input  logic  pop,
    output byte_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          do_push;
    logic          do_pop;

    assign full    = (occ == FULL_OCC);
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? byte_t'(0) : mem[rd_ptr];

    // Storage array: written only on an accepted push, never reset (gated by empty).
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/demux_2x8_stream.sv
// Routes one byte stream to one of two buffered output streams, chosen per byte by SEL.
// Handshake: every port pair uses valid/ready; a transfer happens on a rising
// edge where both are high. Valid never waits for ready, data and valid are
// held by the sender until the transfer, and ready may depend combinationally
// on the sideband (ENT_READY follows SEL, never ENT_VALID).
module demux_2x8_stream
    import demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] ENT,
    input  logic       ENT_VALID,
    input  logic       SEL,
    output logic       ENT_READY,
    output logic [7:0] OUT1,
    output logic       OUT1_VALID,
    input  logic       OUT1_READY,
    output logic [7:0] OUT2,
    output logic       OUT2_VALID,
    input  logic       OUT2_READY,
    output logic [7:0] CNT1,
    output logic [7:0] CNT2
);

    logic full1;
    logic full2;
    logic empty1;
    logic empty2;
    logic accept;
    logic push1;
    logic push2;

    // A stalled side only blocks bytes addressed to it.
    always_comb begin
        ENT_READY = (SEL == SEL_OUT2) ? !full2 : !full1;
        accept    = ENT_VALID && ENT_READY;
        push1     = accept && (SEL == SEL_OUT1);
        push2     = accept && (SEL == SEL_OUT2);
    end

    assign OUT1_VALID = !empty1;
    assign OUT2_VALID = !empty2;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (push1),
        .din     (ENT),
        .pop     (OUT1_READY),
        .dout    (OUT1),
        .full    (full1),
        .empty   (empty1)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_fifo2 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (push2),
        .din     (ENT),
        .pop     (OUT2_READY),
        .dout    (OUT2),
        .full    (full2),
        .empty   (empty2)
    );

    // Accepted-byte counters per destination, wrapping modulo 256.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            CNT1 <= 8'h00;
            CNT2 <= 8'h00;
        end else begin
            if (push1) begin
                CNT1 <= CNT1 + 8'h01;
            end
            if (push2) begin
                CNT2 <= CNT2 + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_demux_2x8_stream.sv
// Directed bench for demux_2x8_stream with hand-computed expectations.
module tb_demux_2x8_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] ent;
    logic       ent_valid;
    logic       sel;
    logic       ent_ready;
    logic [7:0] out1;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out2;
    logic       out2_valid;
    logic       out2_ready;
    logic [7:0] cnt1;
    logic [7:0] cnt2;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    demux_2x8_stream #(.DEPTH(4)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .ENT        (ent),
        .ENT_VALID  (ent_valid),
        .SEL        (sel),
        .ENT_READY  (ent_ready),
        .OUT1       (out1),
        .OUT1_VALID (out1_valid),
        .OUT1_READY (out1_ready),
        .OUT2       (out2),
        .OUT2_VALID (out2_valid),
        .OUT2_READY (out2_ready),
        .CNT1       (cnt1),
        .CNT2       (cnt2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; all sampling and driving happens 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ent        = 8'h00;
        ent_valid  = 1'b0;
        sel        = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    // Offer one byte for a single edge (caller ensures ENT_READY).
    task automatic push_byte(input logic s, input logic [7:0] d);
        sel       = s;
        ent       = d;
        ent_valid = 1'b1;
        step();
        ent_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;

        // Reset state
        check_val("rst_out1_valid", {31'b0, out1_valid}, 0);
        check_val("rst_out2_valid", {31'b0, out2_valid}, 0);
        check_val("rst_out1", {24'b0, out1}, 0);
        check_val("rst_out2", {24'b0, out2}, 0);
        check_val("rst_cnt1", {24'b0, cnt1}, 0);
        check_val("rst_cnt2", {24'b0, cnt2}, 0);
        rst_n = 1'b1;
        step();

        // Single byte to OUT1
        push_byte(1'b0, 8'hA5);
        check_val("t1_out1_valid", {31'b0, out1_valid}, 1);
        check_val("t1_out1", {24'b0, out1}, 32'hA5);
        check_val("t1_out2_valid", {31'b0, out2_valid}, 0);
        check_val("t1_cnt1", {24'b0, cnt1}, 1);
        check_val("t1_cnt2", {24'b0, cnt2}, 0);
        step();
        check_val("t1_hold", {24'b0, out1}, 32'hA5);
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        check_val("t1_popped", {31'b0, out1_valid}, 0);

        // Fill OUT2 while its consumer stalls; OUT1 path stays open
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check_val("t2_ready_before", {31'b0, ent_ready}, 1);
            push_byte(1'b1, 8'h10 + 8'(i));
        end
        sel = 1'b1;
        #1;
        check_val("t2_full_ready_sel1", {31'b0, ent_ready}, 0);
        sel = 1'b0;
        #1;
        check_val("t2_ready_sel0", {31'b0, ent_ready}, 1);
        push_byte(1'b0, 8'h55);
        check_val("t2_out1_valid", {31'b0, out1_valid}, 1);
        check_val("t2_out1", {24'b0, out1}, 32'h55);
        check_val("t2_cnt2", {24'b0, cnt2}, 4);
        out2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("t2_out2_valid", {31'b0, out2_valid}, 1);
            check_val("t2_out2_order", {24'b0, out2}, 32'h10 + i);
            step();
        end
        check_val("t2_out2_drained", {31'b0, out2_valid}, 0);
        out2_ready = 1'b0;

        // Back-to-back push/pop on OUT1: one entry at a time
        do_reset();
        out1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_byte(1'b0, 8'(i));
            check_val("t3_valid", {31'b0, out1_valid}, 1);
            check_val("t3_data", {24'b0, out1}, i);
        end
        step();
        check_val("t3_empty_after", {31'b0, out1_valid}, 0);
        check_val("t3_cnt1", {24'b0, cnt1}, 10);
        out1_ready = 1'b0;

        // 300 bytes through OUT2 with an always-ready consumer
        do_reset();
        exp_q.delete();
        out2_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sel       = 1'b1;
            ent       = 8'(i * 7 + 3);
            ent_valid = 1'b1;
            #1;
            if (ent_ready) exp_q.push_back(ent);
            step();
            ent_valid = 1'b0;
            if (out2_valid) begin
                if (exp_q.size() == 0) check_val("t4_unexpected", {24'b0, out2}, 32'hFFFF_FFFF);
                else check_val("t4_data", {24'b0, out2}, {24'b0, exp_q.pop_front()});
            end
        end
        step();
        check_val("t4_q_empty", exp_q.size(), 0);
        check_val("t4_out2_empty", {31'b0, out2_valid}, 0);
        check_val("t4_cnt2", {24'b0, cnt2}, 44);
        out2_ready = 1'b0;

        // Hold against a full FIFO 1, then a single pop admits exactly one byte
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(1'b0, 8'h20 + 8'(i));
        sel       = 1'b0;
        ent       = 8'h99;
        ent_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("t5_blocked_ready", {31'b0, ent_ready}, 0);
            step();
            check_val("t5_cnt1_held", {24'b0, cnt1}, 4);
        end
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        check_val("t5_ready_after_pop", {31'b0, ent_ready}, 1);
        check_val("t5_cnt1_no_early", {24'b0, cnt1}, 4);
        step();
        ent_valid = 1'b0;
        check_val("t5_cnt1_one_accept", {24'b0, cnt1}, 5);
        check_val("t5_full_again", {31'b0, ent_ready}, 0);
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("t5_drain", {24'b0, out1}, (i < 3) ? (32'h21 + i) : 32'h99);
            step();
        end
        check_val("t5_drained", {31'b0, out1_valid}, 0);
        out1_ready = 1'b0;

        // Asynchronous reset mid-cycle with both FIFOs loaded
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_byte(1'b0, 8'h30 + 8'(i));
            push_byte(1'b1, 8'h40 + 8'(i));
        end
        check_val("t6_cnt1_pre", {24'b0, cnt1}, 3);
        check_val("t6_cnt2_pre", {24'b0, cnt2}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_out1_valid", {31'b0, out1_valid}, 0);
        check_val("t6_out2_valid", {31'b0, out2_valid}, 0);
        check_val("t6_cnt1", {24'b0, cnt1}, 0);
        check_val("t6_cnt2", {24'b0, cnt2}, 0);
        check_val("t6_out1_zero", {24'b0, out1}, 0);
        step();
        rst_n = 1'b1;
        push_byte(1'b1, 8'h77);
        check_val("t6_new_valid", {31'b0, out2_valid}, 1);
        check_val("t6_new_data", {24'b0, out2}, 32'h77);
        check_val("t6_new_cnt2", {24'b0, cnt2}, 1);
        check_val("t6_out1_stale", {31'b0, out1_valid}, 0);
        out2_ready = 1'b1;
        step();
        check_val("t6_no_stale", {31'b0, out2_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout got=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
